// File: rtl/mux_pkg.sv
// mux_pkg: shared definitions for the registered N:1 scan multiplexer.
//   MODE_DIRECT / MODE_SCAN : encodings of the `mode` input.
//   clog2_min1(n)           : max(1, $clog2(n)), so a 2-channel or
//                             1-cycle-dwell build still gets 1-bit fields.
package mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_scan_ctr.sv
// mux_scan_ctr: round-robin scan pointer with per-channel dwell counter.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   en         : advance the scan by one cycle
//   restart    : treat ptr/dcnt as 0 this cycle; with en low it clears them
//   ptr        : channel to present this cycle (already restart-adjusted)
//   wrap_next  : this cycle presents channel 0 right after channel N_CH-1
module mux_scan_ctr
    import mux_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int DWELL = 4,
    parameter int SEL_W = clog2_min1(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    output logic [SEL_W-1:0] ptr,
    output logic             wrap_next
);

    localparam int                DCNT_W    = clog2_min1(DWELL);
    localparam logic [SEL_W-1:0]  LAST_CH   = SEL_W'(N_CH - 1);
    localparam logic [DCNT_W-1:0] LAST_DCNT = DCNT_W'(DWELL - 1);

    logic [SEL_W-1:0]  ptr_q;
    logic [DCNT_W-1:0] dcnt_q;
    logic              wrap_pend;   // pointer just rolled over to 0
    logic [SEL_W-1:0]  cur_ptr;
    logic [DCNT_W-1:0] cur_dcnt;
    logic              dwell_done;

    always_comb begin
        cur_ptr    = restart ? '0 : ptr_q;
        cur_dcnt   = restart ? '0 : dcnt_q;
        dwell_done = (cur_dcnt == LAST_DCNT);
    end

    assign ptr = cur_ptr;
    // The rollover is flagged when the pointer moves to 0, but reported on
    // the following scan cycle so it lines up with y_ch showing channel 0.
    assign wrap_next = en & ~restart & wrap_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            dcnt_q    <= '0;
            wrap_pend <= 1'b0;
        end else if (en) begin
            if (dwell_done) begin
                dcnt_q    <= '0;
                ptr_q     <= (cur_ptr == LAST_CH) ? '0 : cur_ptr + SEL_W'(1);
                wrap_pend <= (cur_ptr == LAST_CH);
            end else begin
                dcnt_q    <= cur_dcnt + DCNT_W'(1);
                ptr_q     <= cur_ptr;
                wrap_pend <= 1'b0;
            end
        end else if (restart) begin
            ptr_q     <= '0;
            dcnt_q    <= '0;
            wrap_pend <= 1'b0;
        end
    end

endmodule

// File: rtl/mux_scan_sel.sv
// mux_scan_sel: registered N_CH:1 multiplexer with direct and auto-scan modes.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   d        : packed channel data, channel k at d[k*W +: W]
//   sel      : channel select (direct mode)
//   mode     : 0 = direct, 1 = scan
//   en       : enable; low freezes all state and drops y_valid / wrap
//   y        : registered selected data
//   y_valid  : y holds a valid sample taken on the previous edge
//   y_ch     : channel index y was taken from
//   wrap     : one-cycle pulse when scan returns to channel 0
module mux_scan_sel
    import mux_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int W     = 1,
    parameter int SEL_W = clog2_min1(N_CH),
    parameter int DWELL = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH*W-1:0]   d,
    input  logic [SEL_W-1:0]    sel,
    input  logic                mode,
    input  logic                en,
    output logic [W-1:0]        y,
    output logic                y_valid,
    output logic [SEL_W-1:0]    y_ch,
    output logic                wrap
);

    logic             mode_q;
    logic             scan_en;
    logic             restart;
    logic [SEL_W-1:0] ptr;
    logic             wrap_next;
    logic [W-1:0]     sel_data;
    logic [W-1:0]     scan_data;
    logic             sel_ok;

    assign scan_en = en & (mode == MODE_SCAN);
    // Any enabled direct cycle parks the scan at channel 0 / dwell 0, and the
    // first scan cycle after direct mode starts from there regardless.
    assign restart = en & ((mode == MODE_DIRECT) | (mode_q == MODE_DIRECT));

    mux_scan_ctr #(
        .N_CH  (N_CH),
        .DWELL (DWELL),
        .SEL_W (SEL_W)
    ) u_ctr (
        .clk       (clk),
        .rst       (rst),
        .en        (scan_en),
        .restart   (restart),
        .ptr       (ptr),
        .wrap_next (wrap_next)
    );

    // Decoded selection avoids indexing past the bus when sel >= N_CH.
    always_comb begin
        sel_data  = '0;
        scan_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel == SEL_W'(k)) sel_data  = d[k*W +: W];
            if (ptr == SEL_W'(k)) scan_data = d[k*W +: W];
        end
        sel_ok = (32'(sel) < N_CH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y       <= '0;
            y_valid <= 1'b0;
            y_ch    <= '0;
            wrap    <= 1'b0;
            mode_q  <= MODE_DIRECT;
        end else if (!en) begin
            y_valid <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            mode_q <= mode;
            if (mode == MODE_SCAN) begin
                y       <= scan_data;
                y_ch    <= ptr;
                y_valid <= 1'b1;
                wrap    <= wrap_next;
            end else begin
                y       <= sel_ok ? sel_data : '0;
                y_ch    <= sel;
                y_valid <= sel_ok;
                wrap    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_sel.sv
// tb_mux_scan_sel: directed bench for mux_scan_sel.
// Two instances: A (8 ch x 1 bit, dwell 2) and B (6 ch x 4 bit, dwell 1).
// A cycle-count model predicts every output on every edge; literal checks
// in the stimulus pin the model against hand-computed values.
module tb_mux_scan_sel;

    typedef struct packed {
        int s;      // enabled scan cycles since entering scan
        int y;
        bit vld;
        int ch;
        bit wrap;
    } mst_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, en_a, mode_a;
    logic [7:0]  d_a;
    logic [2:0]  sel_a;
    logic        y_a, yv_a, wr_a;
    logic [2:0]  ych_a;

    logic        rst_b, en_b, mode_b;
    logic [23:0] d_b;
    logic [2:0]  sel_b;
    logic [3:0]  y_b;
    logic        yv_b, wr_b;
    logic [2:0]  ych_b;

    int   checks   = 0;
    int   failures = 0;
    bit   chk_on   = 1'b0;
    mst_t ma = '0;
    mst_t mb = '0;

    int exp_y_scan[17] = '{0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1,0};
    int sel_b_tab[3]   = '{5, 6, 7};

    mux_scan_sel #(.N_CH(8), .W(1), .SEL_W(3), .DWELL(2)) dut_a (
        .clk(clk), .rst(rst_a), .d(d_a), .sel(sel_a), .mode(mode_a), .en(en_a),
        .y(y_a), .y_valid(yv_a), .y_ch(ych_a), .wrap(wr_a)
    );

    mux_scan_sel #(.N_CH(6), .W(4), .SEL_W(3), .DWELL(1)) dut_b (
        .clk(clk), .rst(rst_b), .d(d_b), .sel(sel_b), .mode(mode_b), .en(en_b),
        .y(y_b), .y_valid(yv_b), .y_ch(ych_b), .wrap(wr_b)
    );

    // Scan position is a plain count of enabled scan cycles: channel is
    // (count / dwell) mod n, and a wrap is every full n*dwell period.
    function automatic mst_t step(mst_t m, int n, int dw, int w, logic [31:0] d,
                                  int sel, bit mode, bit en, bit rst);
        mst_t r = m;
        int p;
        logic [31:0] msk = (32'd1 << w) - 32'd1;
        if (rst) begin
            r = '0;
        end else if (!en) begin
            r.vld  = 1'b0;
            r.wrap = 1'b0;
        end else if (mode) begin
            p      = (m.s / dw) % n;
            r.ch   = p;
            r.y    = int'((d >> (p * w)) & msk);
            r.vld  = 1'b1;
            r.wrap = (m.s > 0) && (m.s % (dw * n) == 0);
            r.s    = m.s + 1;
        end else begin
            r.s    = 0;
            r.ch   = sel;
            r.wrap = 1'b0;
            if (sel < n) begin
                r.y   = int'((d >> (sel * w)) & msk);
                r.vld = 1'b1;
            end else begin
                r.y   = 0;
                r.vld = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        ma <= step(ma, 8, 2, 1, {24'd0, d_a}, int'(sel_a), mode_a, en_a, rst_a);
        mb <= step(mb, 6, 1, 4, {8'd0, d_b},  int'(sel_b), mode_b, en_b, rst_b);
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_a_y",    int'(y_a),   ma.y);
            chk("model_a_vld",  int'(yv_a),  int'(ma.vld));
            chk("model_a_ch",   int'(ych_a), ma.ch);
            chk("model_a_wrap", int'(wr_a),  int'(ma.wrap));
            chk("model_b_y",    int'(y_b),   mb.y);
            chk("model_b_vld",  int'(yv_b),  int'(mb.vld));
            chk("model_b_ch",   int'(ych_b), mb.ch);
            chk("model_b_wrap", int'(wr_b),  int'(mb.wrap));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b1; en_a = 1'b1; mode_a = 1'b0; sel_a = '0; d_a = 8'b10101010;
        rst_b = 1'b1; en_b = 1'b1; mode_b = 1'b0; sel_b = '0; d_b = 24'h654321;
        tick();
        chk_on = 1'b1;
        chk("reset_y",    int'(y_a),   0);
        chk("reset_vld",  int'(yv_a),  0);
        chk("reset_ch",   int'(ych_a), 0);
        chk("reset_wrap", int'(wr_a),  0);
        chk("reset_b_vld", int'(yv_b), 0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Direct select on A; B probes the top channel and out-of-range selects.
        for (int i = 0; i < 8; i++) begin
            sel_a = 3'(i);
            if (i < 3) sel_b = 3'(sel_b_tab[i]);
            tick();
            chk("dir_a_y",   int'(y_a),   i & 1);
            chk("dir_a_ch",  int'(ych_a), i);
            chk("dir_a_vld", int'(yv_a),  1);
            chk("dir_a_wrap", int'(wr_a), 0);
            if (i == 0) begin
                chk("dir_b_sel5_y",   int'(y_b),  6);
                chk("dir_b_sel5_vld", int'(yv_b), 1);
            end else if (i < 3) begin
                chk("dir_b_oor_y",   int'(y_b),   0);
                chk("dir_b_oor_vld", int'(yv_b),  0);
                chk("dir_b_oor_ch",  int'(ych_b), sel_b_tab[i]);
            end
        end

        // Scan on A from reset (dwell 2); B enters scan from direct (dwell 1).
        d_a = 8'b11001100;
        rst_a = 1'b1; mode_a = 1'b1;
        tick();
        rst_a = 1'b0;
        mode_b = 1'b1;
        for (int i = 0; i < 23; i++) begin
            tick();
            if (i < 17) begin
                chk("scan_a_ch",   int'(ych_a), (i / 2) % 8);
                chk("scan_a_y",    int'(y_a),   exp_y_scan[i]);
                chk("scan_a_wrap", int'(wr_a),  (i == 16) ? 1 : 0);
                chk("scan_b_ch",   int'(ych_b), i % 6);
                chk("scan_b_y",    int'(y_b),   (i % 6) + 1);
                chk("scan_b_wrap", int'(wr_b),  (i == 6 || i == 12) ? 1 : 0);
            end
        end
        chk("freeze_entry_ch", int'(ych_a), 3);

        // Freeze A on the first sample of channel 3.
        en_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("freeze_ch",   int'(ych_a), 3);
            chk("freeze_y",    int'(y_a),   1);
            chk("freeze_vld",  int'(yv_a),  0);
            chk("freeze_wrap", int'(wr_a),  0);
        end
        en_a = 1'b1;
        tick();
        chk("unfreeze_ch3", int'(ych_a), 3);
        chk("unfreeze_vld", int'(yv_a),  1);
        tick();
        chk("unfreeze_ch4", int'(ych_a), 4);

        // Reset A while it presents channel 5.
        tick();
        tick();
        chk("pre_rst_ch5", int'(ych_a), 5);
        rst_a = 1'b1;
        tick();
        chk("midrst_y",   int'(y_a),   0);
        chk("midrst_vld", int'(yv_a),  0);
        chk("midrst_ch",  int'(ych_a), 0);
        rst_a = 1'b0;
        tick();
        chk("restart_ch0a",  int'(ych_a), 0);
        chk("restart_wrap",  int'(wr_a),  0);
        tick();
        chk("restart_ch0b",  int'(ych_a), 0);
        tick();
        chk("restart_ch1",   int'(ych_a), 1);

        // Mode switching on A.
        mode_a = 1'b0; sel_a = 3'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("msw_dir_ch", int'(ych_a), 4);
            chk("msw_dir_y",  int'(y_a),   0);
        end
        mode_a = 1'b1;
        tick();
        chk("msw_scan_ch0a", int'(ych_a), 0);
        chk("msw_scan_wrap", int'(wr_a),  0);
        tick();
        chk("msw_scan_ch0b", int'(ych_a), 0);
        tick();
        chk("msw_scan_ch1",  int'(ych_a), 1);
        mode_a = 1'b0; sel_a = 3'd2;
        tick();
        chk("msw_back_ch",  int'(ych_a), 2);
        chk("msw_back_y",   int'(y_a),   1);
        chk("msw_back_vld", int'(yv_a),  1);

        // B: freeze across a rollover, then resume; model covers the timing.
        en_b = 1'b0;
        tick();
        tick();
        en_b = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        d_b = 24'h9ABCDE;
        for (int i = 0; i < 4; i++) tick();

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
